cf_apb_initiator: RTL and testbench

//  APB3 requester (initiator) that turns a valid/ready command stream into single APB transfers toward any
//  CF_* APB peripheral (e.g. CF_UART_APB). Returns read data/status on a valid/ready response channel.

---
 rtl/cf_apb_pkg.sv | 15 +
 rtl/cf_apb_timer.sv | 29 ++
 rtl/cf_apb_initiator.sv | 112 +++++++++++
 tb/tb_cf_apb_initiator.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_apb_pkg.sv
// Shared APB initiator definitions: FSM state encoding and response status bit positions.
package cf_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned RSP_ERR_BIT     = 0;
  localparam int unsigned RSP_TIMEOUT_BIT = 1;
  localparam int unsigned RSP_STATUS_W    = 2;

endpackage

// File: rtl/cf_apb_timer.sv
// Saturating wait-state counter; expired flags the enabled cycle that reaches TIMEOUT.
module cf_apb_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en && (TIMEOUT != 0) && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the cycle whose increment would make the count equal TIMEOUT.
  assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/cf_apb_initiator.sv
// APB3 initiator: one valid/ready command becomes one APB transfer, answered on a valid/ready response.
module cf_apb_initiator
  import cf_apb_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic [AW-1:0] PADDR,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);

  apb_state_e                state;
  logic [RSP_STATUS_W-1:0]   rsp_status;
  logic                      timer_clr;
  logic                      timer_en;
  logic                      timer_expired;

  assign cmd_ready   = (state == ST_IDLE) && PRESETn;
  assign rsp_err     = rsp_status[RSP_ERR_BIT];
  assign rsp_timeout = rsp_status[RSP_TIMEOUT_BIT];
  assign timer_clr   = (state == ST_IDLE) && cmd_valid;
  assign timer_en    = (state == ST_ACCESS) && !PREADY;

  cf_apb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state      <= ST_IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr & ADDR_MASK;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY is checked first so a completion on the timeout cycle is not reported as an abort.
          if (PREADY) begin
            PSEL                        <= 1'b0;
            PENABLE                     <= 1'b0;
            rsp_valid                   <= 1'b1;
            rsp_rdata                   <= PWRITE ? '0 : PRDATA;
            rsp_status[RSP_ERR_BIT]     <= PSLVERR;
            rsp_status[RSP_TIMEOUT_BIT] <= 1'b0;
            state                       <= ST_RESP;
          end else if (timer_expired) begin
            PSEL                        <= 1'b0;
            PENABLE                     <= 1'b0;
            rsp_valid                   <= 1'b1;
            rsp_rdata                   <= '0;
            rsp_status[RSP_ERR_BIT]     <= 1'b1;
            rsp_status[RSP_TIMEOUT_BIT] <= 1'b1;
            state                       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cf_apb_initiator.sv
// Directed bench for cf_apb_initiator against a small APB slave model with configurable wait states.
module tb_cf_apb_initiator;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int failures = 0;

  int          wait_cfg = 0;
  bit          stuck = 1'b0;
  bit          err_inj = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] mem [0:15];

  cf_apb_initiator #(
    .AW(16),
    .DW(32),
    .TIMEOUT(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  always_comb begin
    PREADY  = !stuck && (acc_cnt >= wait_cfg);
    PRDATA  = mem[PADDR[5:2]];
    PSLVERR = err_inj && PSEL && PENABLE;
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [31:0] d);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready});
    end
    checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== 80'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {PADDR, PWDATA, rsp_rdata});
    end
    PRESETn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_write_read();
    wait_cfg = 0; stuck = 0; err_inj = 0;
    send_cmd(1'b1, 16'h0008, 32'd10);
    checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 4'b1010 || PADDR !== 16'h0008 || PWDATA !== 32'd10) begin
      failures++;
      $display("FAIL wr_setup got=%b addr=%h data=%h exp=1010 addr=0008 data=0000000a",
               {PSEL, PENABLE, PWRITE, rsp_valid}, PADDR, PWDATA);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      failures++;
      $display("FAIL wr_access got=%b exp=110", {PSEL, PENABLE, rsp_valid});
    end
    tick();
    checks++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout} !== 5'b00100 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL wr_resp got=%b rdata=%h exp=00100 rdata=0",
               {PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_done got=%b%b exp=01", rsp_valid, cmd_ready);
    end
    send_cmd(1'b0, 16'h0008, 32'hFFFF_FFFF);
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd10 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rd_data got=%b %h %b exp=1 0000000a 0", rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
  endtask

  task automatic test_wait_states();
    int  en_cycles = 0;
    bit  stable = 1'b1;
    bit  seen = 1'b0;
    wait_cfg = 5;
    send_cmd(1'b1, 16'h0010, 32'h1234_5678);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (PENABLE) en_cycles++;
      if (PSEL && (PADDR !== 16'h0010 || PWDATA !== 32'h1234_5678 || PWRITE !== 1'b1)) stable = 1'b0;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ws_rsp got=no_rsp exp=rsp_valid within 20 cycles");
    end
    checks++;
    if (en_cycles != 6) begin
      failures++;
      $display("FAIL ws_penable_cycles got=%0d exp=6", en_cycles);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL ws_stable got=changed exp=stable");
    end
    checks++;
    if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL ws_err got=%b%b exp=00", rsp_err, rsp_timeout);
    end
    tick();
    wait_cfg = 0;
  endtask

  task automatic test_timeout();
    int en_cycles = 0;
    bit seen = 1'b0;
    stuck = 1'b1;
    send_cmd(1'b0, 16'h0020, 32'h0);
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (PENABLE) en_cycles++;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || en_cycles != 8) begin
      failures++;
      $display("FAIL to_cycles got=seen%0d en=%0d exp=seen1 en=8", seen, en_cycles);
    end
    checks++;
    if ({PSEL, PENABLE, rsp_err, rsp_timeout} !== 4'b0011 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL to_status got=%b rdata=%h exp=0011 rdata=0",
               {PSEL, PENABLE, rsp_err, rsp_timeout}, rsp_rdata);
    end
    tick();
    stuck = 1'b0;
  endtask

  task automatic test_slverr();
    err_inj = 1'b1;
    send_cmd(1'b0, 16'h0ABC, 32'h0);
    checks++;
    if (PADDR !== 16'h0ABC || PWRITE !== 1'b0) begin
      failures++;
      $display("FAIL err_addr got=%h %b exp=0abc 0", PADDR, PWRITE);
    end
    tick(); tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
      failures++;
      $display("FAIL err_status got=%b exp=110", {rsp_valid, rsp_err, rsp_timeout});
    end
    tick();
    err_inj = 1'b0;
    send_cmd(1'b0, 16'h0ABF, 32'h0);
    checks++;
    if (PADDR !== 16'h0ABC) begin
      failures++;
      $display("FAIL addr_mask got=%h exp=0abc", PADDR);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 16'h0008, 32'h0);
    tick(); tick();
    cmd_write = 1'b1; cmd_addr = 16'h0030; cmd_wdata = 32'hA5A5_0001;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || PSEL !== 1'b0 || rsp_rdata !== 32'd10) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got=%0d bad cycles exp=0", bad);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got=%b%b%b exp=010", rsp_valid, cmd_ready, PSEL);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (PSEL !== 1'b1 || PADDR !== 16'h0030) begin
      failures++;
      $display("FAIL bp_next got=%b %h exp=1 0030", PSEL, PADDR);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    int setups = 0;
    int first_setup = -1;
    cmd_write = 1'b1; cmd_addr = 16'h0013; cmd_wdata = 32'h55;
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (PSEL && !PENABLE) begin
        setups++;
        if (first_setup < 0) first_setup = i;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (setups != 3 || first_setup != 0) begin
      failures++;
      $display("FAIL b2b_rate got=%0d setups first=%0d exp=3 first=0", setups, first_setup);
    end
    checks++;
    if (PADDR !== 16'h0010) begin
      failures++;
      $display("FAIL b2b_addr got=%h exp=0010", PADDR);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int rsp_seen = 0;
    stuck = 1'b1;
    send_cmd(1'b1, 16'h0004, 32'h77);
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      failures++;
      $display("FAIL rm_access got=%b exp=11", {PSEL, PENABLE});
    end
    PRESETn = 1'b0;
    tick();
    checks++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL rm_drop got=%b exp=0000", {PSEL, PENABLE, rsp_valid, cmd_ready});
    end
    tick();
    stuck = 1'b0;
    PRESETn = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) rsp_seen++;
      tick();
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_seen != 0) begin
      failures++;
      $display("FAIL rm_after got=ready%b rsp%0d exp=ready1 rsp0", cmd_ready, rsp_seen);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
